dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port DATA block RAM between the pipeline MEM stage and a debug/display read port (LCD memory viewer).
- The pipeline has priority.
- The debug port gets a guaranteed slot through a bounded-starvation counter that forces a one-cycle pipeline stall.
- Sits between the `stages` MEM-stage memory signals, the RAM, and the display logic.

Parameters:
- ADDR_W, 10, RAM word-address width
- DATA_W, 32, RAM data width
- STARVE_LIMIT, 8, consecutive blocked cycles before debug access is forced (range 1..255)

Ports:
- clk  in  1  system clock; RAM is synchronous-read with 1-cycle latency on this clock
- rst_n  in  1  asynchronous, active-low reset
- pipe_ren  in  1  MEM-stage read request
- pipe_wen  in  1  MEM-stage write request
- pipe_addr  in  ADDR_W  MEM-stage word address
- pipe_din  in  DATA_W  MEM-stage write data
- pipe_dout  out  DATA_W  read data to MEM stage (= ram_dout)
- pipe_stall  out  1  pipeline must hold MEM stage this cycle
- dbg_req  in  1  debug read request, single-cycle pulse
- dbg_addr  in  ADDR_W  debug word address, sampled with dbg_req
- dbg_busy  out  1  request in flight; new dbg_req ignored
- dbg_ack  out  1  one-cycle pulse: dbg_data valid
- dbg_data  out  DATA_W  registered debug read data
- ram_addr  out  ADDR_W  RAM address
- ram_wen  out  1  RAM write enable
- ram_din  out  DATA_W  RAM write data
- ram_dout  in  DATA_W  RAM read data

Behaviour:
- Interface decided: one clock, clk; reset rst_n, asynchronous, active-low.
- Reset values:
  - state=IDLE, pending=0, addr_q=0, starve_cnt=0
  - dbg_ack=0, dbg_data=0, dbg_busy=0, pipe_stall=0
- pipe_act = pipe_ren | pipe_wen.
- FSM states: IDLE, DBG_ISSUE, DBG_CAPTURE.
- IDLE:
  - RAM driven combinationally from the pipe port: ram_addr=pipe_addr, ram_wen=pipe_wen, ram_din=pipe_din.
  - dbg_req while !dbg_busy sets pending=1 and latches addr_q=dbg_addr.
  - Go to DBG_ISSUE when pending and either (!pipe_act) or (starve_cnt==STARVE_LIMIT).
- DBG_ISSUE (exactly 1 cycle):
  - ram_addr=addr_q, ram_wen=0.
  - pipe_stall=pipe_act (combinational); the pipe access is not performed.
  - Next state DBG_CAPTURE; pending cleared.
- DBG_CAPTURE (1 cycle):
  - Pipe port owns the RAM again, as in IDLE.
  - At the end of the cycle, dbg_data<=ram_dout and dbg_ack pulses 1 in the following cycle (IDLE).
- Debug latency: dbg_req to dbg_ack is at least 3 cycles and at most STARVE_LIMIT+3 cycles.
- dbg_busy = pending | (state!=IDLE).
- starve_cnt:
  - In IDLE, increments while pending & pipe_act, saturating at STARVE_LIMIT.
  - Cleared on entering DBG_ISSUE or when pending=0.
- pipe_stall is 0 in every state except DBG_ISSUE; at most one stall cycle per debug request.
- Simultaneous dbg_req and DBG_CAPTURE→IDLE: the request is accepted, because dbg_busy is already 0 in the ack cycle.
- pipe_ren and pipe_wen both high: treated as a write.
- Reset mid-transaction: the in-flight debug read is aborted and no dbg_ack is issued.

Optional Feature:
- Macro: DMEM_ARB_DBG_WRITE_EN.
- Defined:
  - Adds ports dbg_wen (1, in) and dbg_wdata (DATA_W, in), latched with dbg_req.
  - DBG_ISSUE drives ram_wen=wen_q and ram_din=wdata_q.
  - dbg_ack still pulses; dbg_data returns the RAM read-during-write value.
- Undefined: these ports do not exist and the debug port is read-only.

Decomposition:
- Package dmem_arb_pkg:
  - state enum (IDLE, DBG_ISSUE, DBG_CAPTURE)
  - default ADDR_W/DATA_W constants
  - STARVE_W = $clog2(STARVE_LIMIT+1)
- One sub-module: dmem_arb_starve_cnt, the saturating counter with inc/clr/at_limit.

Test Plan:
- Idle pipe, dbg_req with addr 0x005, RAM[5]=0xDEADBEEF → DBG_ISSUE next cycle; dbg_ack 3 cycles after the request with dbg_data=0xDEADBEEF; pipe_stall never asserts.
- pipe_ren held high continuously, dbg_req addr 0x010, STARVE_LIMIT=8 → exactly one pipe_stall cycle, 9 cycles after acceptance; dbg_ack 2 cycles later with the correct data.
- pipe_wen to addr 0x010 with 0x12345678 in the cycle before the debug read of 0x010 → dbg_data=0x12345678.
- dbg_req pulsed again while dbg_busy=1 with a different address → ignored; only the first address is returned and only one dbg_ack occurs.
- rst_n low during DBG_ISSUE → all outputs return to reset values immediately; no dbg_ack is issued after release.
- With DMEM_ARB_DBG_WRITE_EN: debug write of 0xCAFEF00D to 0x3FF, then a pipe read of 0x3FF → pipe_dout=0xCAFEF00D one cycle after the read.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and defaults for the data-RAM arbiter
package dmem_arb_pkg;

  localparam int DEF_ADDR_W       = 10;
  localparam int DEF_DATA_W       = 32;
  localparam int DEF_STARVE_LIMIT = 8;

  typedef enum logic [1:0] {
    IDLE,
    DBG_ISSUE,
    DBG_CAPTURE
  } arb_state_e;

  // STARVE_W: width able to hold 0..limit
  function automatic int starve_w(input int limit);
    return $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - pipe, debug and RAM signals of the arbiter
// DMEM_ARB_DBG_WRITE_EN adds the debug write fields dbg_wen/dbg_wdata.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              pipe_ren;
  logic              pipe_wen;
  logic [ADDR_W-1:0] pipe_addr;
  logic [DATA_W-1:0] pipe_din;
  logic [DATA_W-1:0] pipe_dout;
  logic              pipe_stall;
  logic              dbg_req;
  logic [ADDR_W-1:0] dbg_addr;
  logic              dbg_busy;
  logic              dbg_ack;
  logic [DATA_W-1:0] dbg_data;
`ifdef DMEM_ARB_DBG_WRITE_EN
  logic              dbg_wen;
  logic [DATA_W-1:0] dbg_wdata;
`endif
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_wen;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout;

  modport slave (
    input  pipe_ren, pipe_wen, pipe_addr, pipe_din, dbg_req, dbg_addr, ram_dout,
`ifdef DMEM_ARB_DBG_WRITE_EN
    input  dbg_wen, dbg_wdata,
`endif
    output pipe_dout, pipe_stall, dbg_busy, dbg_ack, dbg_data, ram_addr, ram_wen, ram_din
  );

  modport master (
    output pipe_ren, pipe_wen, pipe_addr, pipe_din, dbg_req, dbg_addr, ram_dout,
`ifdef DMEM_ARB_DBG_WRITE_EN
    output dbg_wen, dbg_wdata,
`endif
    input  pipe_dout, pipe_stall, dbg_busy, dbg_ack, dbg_data, ram_addr, ram_wen, ram_din
  );
endinterface

// File: rtl/dmem_arb_starve_cnt.sv
// rtl/dmem_arb_starve_cnt.sv - saturating count of cycles a debug request waited
module dmem_arb_starve_cnt
  import dmem_arb_pkg::*;
#(
  parameter int LIMIT = DEF_STARVE_LIMIT,
  parameter int W     = starve_w(LIMIT)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);
  logic [W-1:0] cnt_q, cnt_d;

  assign at_limit = (cnt_q == W'(LIMIT));

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (inc && !at_limit)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - shares the data RAM between the MEM stage and a debug reader
// DMEM_ARB_DBG_WRITE_EN lets the debug port also write through its slot.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic           clk,
  input  logic           rst_n,
  dmem_arbiter_if.slave  bus
);
  arb_state_e        state_q, state_d;
  logic              pending_q, pending_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              dbg_ack_q, dbg_ack_d;
  logic [DATA_W-1:0] dbg_data_q, dbg_data_d;
`ifdef DMEM_ARB_DBG_WRITE_EN
  logic              wen_q, wen_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
`endif
  logic pipe_act, busy, accept, want, go, at_limit, issue;

  assign pipe_act = bus.pipe_ren | bus.pipe_wen;
  assign busy     = pending_q | (state_q != IDLE);
  assign accept   = bus.dbg_req & ~busy;
  // A request arriving this cycle may be issued next cycle without waiting on pending_q.
  assign want     = pending_q | accept;
  assign go       = (state_q == IDLE) & want & (~pipe_act | at_limit);
  assign issue    = (state_q == DBG_ISSUE);

  dmem_arb_starve_cnt #(.LIMIT(STARVE_LIMIT)) u_starve (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      ((state_q == IDLE) & want & pipe_act),
    .clr      (go | ~want),
    .at_limit (at_limit)
  );

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    addr_d     = addr_q;
    dbg_ack_d  = 1'b0;
    dbg_data_d = dbg_data_q;
`ifdef DMEM_ARB_DBG_WRITE_EN
    wen_d      = wen_q;
    wdata_d    = wdata_q;
`endif
    if (accept) begin
      addr_d  = bus.dbg_addr;
`ifdef DMEM_ARB_DBG_WRITE_EN
      wen_d   = bus.dbg_wen;
      wdata_d = bus.dbg_wdata;
`endif
    end
    case (state_q)
      IDLE: begin
        pending_d = want & ~go;
        if (go) state_d = DBG_ISSUE;
      end
      DBG_ISSUE: state_d = DBG_CAPTURE;
      DBG_CAPTURE: begin
        state_d    = IDLE;
        dbg_ack_d  = 1'b1;
        dbg_data_d = bus.ram_dout;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pending_q  <= 1'b0;
      addr_q     <= '0;
      dbg_ack_q  <= 1'b0;
      dbg_data_q <= '0;
`ifdef DMEM_ARB_DBG_WRITE_EN
      wen_q      <= 1'b0;
      wdata_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      addr_q     <= addr_d;
      dbg_ack_q  <= dbg_ack_d;
      dbg_data_q <= dbg_data_d;
`ifdef DMEM_ARB_DBG_WRITE_EN
      wen_q      <= wen_d;
      wdata_q    <= wdata_d;
`endif
    end
  end

  // During the debug slot the pipe access is dropped; the stall makes the stage retry it.
  assign bus.ram_addr   = issue ? addr_q : bus.pipe_addr;
`ifdef DMEM_ARB_DBG_WRITE_EN
  assign bus.ram_wen    = issue ? wen_q : bus.pipe_wen;
  assign bus.ram_din    = issue ? wdata_q : bus.pipe_din;
`else
  assign bus.ram_wen    = issue ? 1'b0 : bus.pipe_wen;
  assign bus.ram_din    = bus.pipe_din;
`endif
  assign bus.pipe_dout  = bus.ram_dout;
  assign bus.pipe_stall = issue & pipe_act;
  assign bus.dbg_busy   = busy;
  assign bus.dbg_ack    = dbg_ack_q;
  assign bus.dbg_data   = dbg_data_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - randomized and directed bench for dmem_arbiter against a transaction model
module tb_dmem_arbiter;
  localparam int LIMIT = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(10), .DATA_W(32)) bus ();

  dmem_arbiter #(.ADDR_W(10), .DATA_W(32), .STARVE_LIMIT(LIMIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Read-first synchronous RAM
  logic [31:0] ram [0:1023];
  always @(posedge clk) begin
    if (bus.ram_wen) ram[bus.ram_addr] <= bus.ram_din;
    bus.ram_dout <= ram[bus.ram_addr];
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Transaction model: a request accepted at cycle acc is decided at the first cycle
  // d >= acc where the pipe is idle or d-acc reaches LIMIT; slot d+1, ack d+3.
  logic [31:0] gm [0:1023];
  int          n = 0;
  bit          inf = 0, dec = 0;
  int          acc, iss, ackc;
  logic [9:0]  m_addr;
  logic        m_wen = 1'b0;
  logic [31:0] m_wdata = '0;
  logic [31:0] exp_data = '0;
  bit          rd_pend = 0;
  logic [31:0] rd_val;
  logic        dw = 1'b0;
  logic [31:0] dwd = '0;
  int          stalls = 0, acks = 0, stall_n = 0, ack_n = 0;

  function automatic logic [31:0] pre(input int a);
    return 32'hA5A50000 | 32'(a);
  endfunction

  task automatic cyc(input logic ren, input logic wen, input logic [9:0] pa,
                     input logic [31:0] pd, input logic req, input logic [9:0] da);
    bit act, e_busy, e_stall, e_ack, slot;
    @(negedge clk);
    bus.pipe_ren = ren; bus.pipe_wen = wen; bus.pipe_addr = pa; bus.pipe_din = pd;
    bus.dbg_req = req; bus.dbg_addr = da;
`ifdef DMEM_ARB_DBG_WRITE_EN
    bus.dbg_wen = dw; bus.dbg_wdata = dwd;
`endif
    #1;
    act     = ren | wen;
    slot    = inf && dec && (n == iss);
    e_busy  = inf && (n > acc) && (!dec || n < ackc);
    e_stall = slot && act;
    e_ack   = inf && dec && (n == ackc);
    check("dbg_busy", 32'(bus.dbg_busy), 32'(e_busy));
    check("pipe_stall", 32'(bus.pipe_stall), 32'(e_stall));
    check("dbg_ack", 32'(bus.dbg_ack), 32'(e_ack));
    if (e_ack) check("dbg_data", bus.dbg_data, exp_data);
    if (rd_pend) check("pipe_dout", bus.pipe_dout, rd_val);
    if (bus.pipe_stall) begin stalls++; stall_n = n; end
    if (bus.dbg_ack) begin acks++; ack_n = n; end
    rd_pend = 0;
    if (slot) begin
      exp_data = gm[m_addr];
      if (m_wen) gm[m_addr] = m_wdata;
    end else if (act) begin
      if (wen) gm[pa] = pd;
      else begin rd_pend = 1; rd_val = gm[pa]; end
    end
    if (e_ack) inf = 0;
    if (req && !e_busy) begin
      inf = 1; dec = 0; acc = n; m_addr = da; m_wen = dw; m_wdata = dwd;
    end
    if (inf && !dec && (!act || (n - acc) == LIMIT)) begin
      dec = 1; iss = n + 1; ackc = n + 3;
    end
    n++;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cyc(1'b0, 1'b0, '0, '0, 1'b0, '0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.pipe_ren = 1'b1; bus.pipe_wen = 1'b0; bus.pipe_addr = '0; bus.pipe_din = '0;
    bus.dbg_req = 1'b0; bus.dbg_addr = '0;
`ifdef DMEM_ARB_DBG_WRITE_EN
    bus.dbg_wen = 1'b0; bus.dbg_wdata = '0;
`endif
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy", 32'(bus.dbg_busy), 32'd0);
    check("rst_ack", 32'(bus.dbg_ack), 32'd0);
    check("rst_data", bus.dbg_data, 32'd0);
    check("rst_stall", 32'(bus.pipe_stall), 32'd0);
    @(negedge clk);
    bus.pipe_ren = 1'b0;
    rst_n = 1'b1;

    for (int a = 0; a < 32; a++) cyc(1'b0, 1'b1, 10'(a), pre(a), 1'b0, '0);
    cyc(1'b0, 1'b1, 10'h3FF, pre(10'h3FF), 1'b0, '0);
    cyc(1'b0, 1'b1, 10'h005, 32'hDEADBEEF, 1'b0, '0);

    // idle pipe: minimum latency, no stall
    stalls = 0;
    cyc(1'b0, 1'b0, '0, '0, 1'b1, 10'h005);
    idle(4);
    check("t1_data", bus.dbg_data, 32'hDEADBEEF);
    check("t1_stalls", 32'(stalls), 32'd0);

    // continuous pipe reads: starvation forces one slot
    stalls = 0; acks = 0;
    cyc(1'b1, 1'b0, 10'h003, '0, 1'b1, 10'h010);
    for (int i = 0; i < 14; i++) cyc(1'b1, 1'b0, 10'(i), '0, 1'b0, '0);
    idle(2);
    check("t2_stalls", 32'(stalls), 32'd1);
    check("t2_stall_at", 32'(stall_n - acc), 32'(LIMIT + 1));
    check("t2_ack_after", 32'(ack_n - stall_n), 32'd2);
    check("t2_data", bus.dbg_data, pre(10'h010));

    // pipe write just before the debug read of the same word
    cyc(1'b0, 1'b1, 10'h010, 32'h12345678, 1'b1, 10'h010);
    idle(4);
    check("t3_data", bus.dbg_data, 32'h12345678);

    // second request while busy is ignored
    acks = 0;
    cyc(1'b0, 1'b0, '0, '0, 1'b1, 10'h005);
    cyc(1'b0, 1'b0, '0, '0, 1'b1, 10'h010);
    idle(6);
    check("t4_acks", 32'(acks), 32'd1);
    check("t4_data", bus.dbg_data, 32'hDEADBEEF);

    // reset while the debug slot is active
    acks = 0;
    cyc(1'b0, 1'b0, '0, '0, 1'b1, 10'h007);
    @(negedge clk);
    bus.dbg_req = 1'b0; bus.pipe_ren = 1'b1;
    #1;
    check("t5_pre_stall", 32'(bus.pipe_stall), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t5_busy", 32'(bus.dbg_busy), 32'd0);
    check("t5_stall", 32'(bus.pipe_stall), 32'd0);
    check("t5_ack", 32'(bus.dbg_ack), 32'd0);
    check("t5_data", bus.dbg_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; bus.pipe_ren = 1'b0;
    inf = 0; rd_pend = 0; n += 2;
    idle(6);
    check("t5_no_ack", 32'(acks), 32'd0);

`ifdef DMEM_ARB_DBG_WRITE_EN
    dw = 1'b1; dwd = 32'hCAFEF00D;
    cyc(1'b0, 1'b0, '0, '0, 1'b1, 10'h3FF);
    dw = 1'b0; dwd = '0;
    idle(4);
    cyc(1'b1, 1'b0, 10'h3FF, '0, 1'b0, '0);
    idle(1);
    check("wr_pipe_dout", bus.pipe_dout, 32'hCAFEF00D);
`endif

    // random traffic with bursts of pipe activity to exercise starvation
    for (int i = 0; i < 3000; i++) begin
      logic busy_pipe, r, w;
      busy_pipe = ($urandom_range(0, 99) < ((i / 300) % 2 == 0 ? 95 : 50));
      r = busy_pipe & $urandom_range(0, 1);
      w = busy_pipe & ~r;
      if (busy_pipe && $urandom_range(0, 7) == 0) r = 1'b1;
      cyc(r, w, 10'($urandom_range(0, 31)), $urandom, ($urandom_range(0, 3) == 0),
          10'($urandom_range(0, 31)));
    end
    idle(LIMIT + 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
